// File: rtl/alarm_ringer.sv
// Alarm ringer: matches a 12-hour alarm setting against a 24-hour clock, then rings,
// snoozes (up to MAX_SNOOZE times) and auto-stops, driven by a once-per-second tick.
module alarm_ringer #(
    parameter int unsigned NOALARM        = 24,
    parameter int unsigned RING_SECONDS   = 60,
    parameter int unsigned SNOOZE_SECONDS = 300,
    parameter int unsigned MAX_SNOOZE     = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1s,
    input  logic [4:0] cur_hours,
    input  logic [5:0] cur_minutes,
    input  logic [5:0] cur_seconds,
    input  logic       alarm_isPM,
    input  logic [4:0] alarm_hours,
    input  logic [5:0] alarm_minutes,
    input  logic       snooze,
    input  logic       dismiss,
    output logic       ringing,
    output logic       snoozed,
    output logic [2:0] snooze_count,
    output logic       alarm_hit
);

    localparam int unsigned RingW    = $clog2(RING_SECONDS + 1);
    localparam logic [2:0]  MaxCount = 3'(MAX_SNOOZE);

    typedef enum logic [1:0] {StIdle, StRinging, StSnooze} state_e;

    state_e           state_q, state_d;
    logic [RingW-1:0] ring_cnt_q, ring_cnt_d;
    logic [8:0]       snz_cnt_q, snz_cnt_d;
    logic [2:0]       snooze_count_q, snooze_count_d;
    logic             ringing_q, ringing_d;
    logic             snoozed_q, snoozed_d;
    logic             alarm_hit_q, alarm_hit_d;

    logic             alarm_en;
    logic [4:0]       target_hours;
    logic             match;

    always_comb begin
        alarm_en = (alarm_hours != 5'(NOALARM)) && (alarm_hours >= 5'd1)
                   && (alarm_hours <= 5'd12);
        // 12 o'clock is the odd one out: 12 AM is hour 0, 12 PM is hour 12.
        if (alarm_hours == 5'd12) begin
            target_hours = alarm_isPM ? 5'd12 : 5'd0;
        end else begin
            target_hours = alarm_isPM ? alarm_hours + 5'd12 : alarm_hours;
        end
        match = tick_1s && (cur_seconds == 6'd0) && (cur_hours == target_hours)
                && (cur_minutes == alarm_minutes) && alarm_en;
    end

    always_comb begin
        state_d        = state_q;
        ring_cnt_d     = ring_cnt_q;
        snz_cnt_d      = snz_cnt_q;
        snooze_count_d = snooze_count_q;
        alarm_hit_d    = 1'b0;

        case (state_q)
            StIdle: begin
                if (match) begin
                    state_d     = StRinging;
                    ring_cnt_d  = RingW'(RING_SECONDS);
                    alarm_hit_d = 1'b1;
                end
            end
            StRinging: begin
                if (!alarm_en || dismiss) begin
                    state_d = StIdle;
                end else if (snooze && (snooze_count_q < MaxCount)) begin
                    state_d        = StSnooze;
                    snooze_count_d = snooze_count_q + 3'd1;
                    snz_cnt_d      = 9'(SNOOZE_SECONDS);
                    ring_cnt_d     = '0;
                end else if (tick_1s) begin
                    ring_cnt_d = (ring_cnt_q == '0) ? '0 : ring_cnt_q - RingW'(1);
                    if (ring_cnt_d == '0) begin
                        state_d = StIdle;
                    end
                end
            end
            StSnooze: begin
                if (!alarm_en || dismiss) begin
                    state_d = StIdle;
                end else if (tick_1s) begin
                    snz_cnt_d = (snz_cnt_q == '0) ? '0 : snz_cnt_q - 9'd1;
                    if (snz_cnt_d == '0) begin
                        state_d    = StRinging;
                        ring_cnt_d = RingW'(RING_SECONDS);
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Any return to idle ends the event and forgets its counters.
        if (state_d == StIdle) begin
            ring_cnt_d     = '0;
            snz_cnt_d      = '0;
            snooze_count_d = '0;
        end

        ringing_d = (state_d == StRinging);
        snoozed_d = (state_d == StSnooze);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= StIdle;
            ring_cnt_q     <= '0;
            snz_cnt_q      <= '0;
            snooze_count_q <= '0;
            ringing_q      <= 1'b0;
            snoozed_q      <= 1'b0;
            alarm_hit_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            ring_cnt_q     <= ring_cnt_d;
            snz_cnt_q      <= snz_cnt_d;
            snooze_count_q <= snooze_count_d;
            ringing_q      <= ringing_d;
            snoozed_q      <= snoozed_d;
            alarm_hit_q    <= alarm_hit_d;
        end
    end

    assign ringing      = ringing_q;
    assign snoozed      = snoozed_q;
    assign snooze_count = snooze_count_q;
    assign alarm_hit    = alarm_hit_q;

endmodule

// File: doc/alarm_ringer.md
ALARM_RINGER -- requirements
Module: alarm_ringer

Interface
REQ-001 Parameters, one per line: name, default, meaning.
  NOALARM  24  alarm_hours value meaning "no alarm set"
  RING_SECONDS  60  seconds a ring lasts before auto-stop
  SNOOZE_SECONDS  300  seconds between snooze and re-ring
  MAX_SNOOZE  3  snoozes allowed per alarm event
REQ-002 Ports, one per line: name  direction  width  meaning; clock and reset first.
  clk  in  1  single clock, all logic on rising edge
  reset  in  1  synchronous, active-low reset
  tick_1s  in  1  one-cycle pulse, once per second
  cur_hours  in  5  current time, 24-hour, 0..23
  cur_minutes  in  6  current minutes, 0..59
  cur_seconds  in  6  current seconds, 0..59, valid with tick_1s
  alarm_isPM  in  1  alarm AM/PM flag
  alarm_hours  in  5  alarm hours, 12-hour, 1..12 or NOALARM
  alarm_minutes  in  6  alarm minutes, 0..59
  snooze  in  1  one-cycle snooze request
  dismiss  in  1  one-cycle dismiss request
  ringing  out  1  alarm sounding
  snoozed  out  1  snooze period active
  snooze_count  out  3  snoozes used in current event
  alarm_hit  out  1  one-cycle pulse on time match

Function
REQ-003 Alarm target converted combinationally to 24-hour: 12 AM -> 0; 12 PM -> 12; h AM -> h; h PM -> h+12 (h 1..11).
REQ-004 alarm_hours outside 1..12 (incl. NOALARM) shall disable matching.
REQ-005 Match: tick_1s high, cur_seconds==0, cur_hours==target hours, cur_minutes==alarm_minutes, alarm enabled.
REQ-006 State machine: IDLE, RINGING, SNOOZE; all outputs registered.
REQ-007 IDLE + match -> RINGING; ringing=1 and alarm_hit=1 for one cycle, both from the cycle after the match edge; ring counter loaded to RING_SECONDS.
REQ-008 Match in RINGING or SNOOZE ignored; alarm_hit not pulsed.
REQ-009 RINGING: ring counter decrements on each tick_1s; on reaching 0 -> IDLE, snooze_count cleared.
REQ-010 RINGING + snooze with snooze_count<MAX_SNOOZE -> SNOOZE; snooze_count+1; snooze timer loaded to SNOOZE_SECONDS; ringing=0, snoozed=1 next cycle.
REQ-011 RINGING + snooze with snooze_count==MAX_SNOOZE: ignored, ringing continues.
REQ-012 SNOOZE: timer (9 bits) decrements on each tick_1s; on reaching 0 -> RINGING, ring counter reloaded, snoozed=0, ringing=1; snooze_count held.
REQ-013 dismiss in RINGING or SNOOZE -> IDLE next cycle; ringing=0, snoozed=0, snooze_count=0.
REQ-014 dismiss and snooze same cycle: dismiss wins.
REQ-015 Alarm disabled (REQ-004) while RINGING or SNOOZE -> IDLE next cycle, counters cleared.
REQ-016 snooze/dismiss in IDLE: no effect.
REQ-017 Re-trigger only on a later seconds==0 match; dismiss within the matching minute shall not re-ring that minute.
REQ-018 Counters saturate at 0; never wrap.

Reset
REQ-019 reset low at a clk edge: state IDLE, ringing=0, snoozed=0, snooze_count=0, alarm_hit=0, counters 0; overrides all inputs incl. a same-cycle match.
REQ-020 Reset mid-RINGING/SNOOZE aborts the event; no re-ring until next match.

Verification
REQ-021 alarm 7:30 AM, clock 07:29:59 -> 07:30:00 tick -> alarm_hit 1 cycle, ringing=1 next cycle.
REQ-022 alarm 12:00 AM matches 00:00:00; 12:05 PM matches 12:05:00; 11:15 PM matches 23:15:00, not 11:15:00.
REQ-023 ringing, no input, 60 ticks -> ringing=0 after 60th tick, state IDLE.
REQ-024 ringing, snooze -> snoozed=1, snooze_count=1; 300 ticks -> ringing=1; repeat to count 3; 4th snooze ignored; dismiss -> all outputs 0.
REQ-025 snooze+dismiss same cycle -> IDLE, snooze_count=0; alarm_hours=24 -> no match at any time.
REQ-026 reset low during SNOOZE -> all outputs 0 next edge; no ring when snooze timer would have expired.
